// File: rtl/lpm_pkg.sv
// lpm_pkg: shared definitions for the LPM route table.
//   - table geometry (LPM_DEPTH entries, LPM_ADDR_WIDTH-bit addresses)
//   - bit positions of the four 32-bit fields inside a 128-bit entry
//   - entry/result typedefs and the per-entry prefix match helper
package lpm_pkg;

  localparam int LPM_DEPTH      = 32;
  localparam int LPM_ADDR_WIDTH = 5;

  // Entry layout: {ip, mask, oq, next_hop}
  localparam int LPM_IP_MSB   = 127;
  localparam int LPM_IP_LSB   = 96;
  localparam int LPM_MASK_MSB = 95;
  localparam int LPM_MASK_LSB = 64;
  localparam int LPM_OQ_MSB   = 63;
  localparam int LPM_OQ_LSB   = 32;
  localparam int LPM_NH_MSB   = 31;
  localparam int LPM_NH_LSB   = 0;

  typedef logic [127:0] lpm_entry_t;
  typedef logic [63:0]  lpm_result_t;

  // True when ip falls inside the entry's prefix; validity is checked by the caller.
  function automatic logic entry_match(input lpm_entry_t e, input logic [31:0] ip);
    logic [31:0] mask;
    mask = e[LPM_MASK_MSB:LPM_MASK_LSB];
    return ((ip & mask) == (e[LPM_IP_MSB:LPM_IP_LSB] & mask));
  endfunction

endpackage

// File: rtl/lpm_prio_enc32.sv
// lpm_prio_enc32: combinational lowest-index priority encoder.
// Ports:
//   vec   in  32  request vector (bit i = entry i matched)
//   any   out 1   at least one bit of vec is set
//   index out 5   index of the lowest set bit; 0 when vec is all zero
module lpm_prio_enc32 (
  input  logic [31:0] vec,
  output logic        any,
  output logic [4:0]  index
);

  // Scanning from the top down lets the lowest set bit overwrite all others,
  // so the lowest index (longest prefix, since software sorts) wins.
  always_comb begin
    any   = |vec;
    index = '0;
    for (int i = 31; i >= 0; i--) begin
      if (vec[i]) index = 5'(i);
    end
  end

endmodule

// File: rtl/lpm_table_match.sv
// lpm_table_match: 32-entry longest-prefix-match route table.
// Holds the table registers, services register-side read/write requests and
// answers destination-IP lookups through a 2-stage pipeline (throughput 1/cycle).
// Ports:
//   AXI_ACLK / AXI_RESET             clock, asynchronous active-high reset
//   tbl_wr_req/addr/data, wr_ack     table write, ack one cycle after request
//   tbl_rd_req/addr, rd_data, rd_ack table read, data+ack one cycle after request
//   lookup_req, lookup_ip            lookup request, sampled every cycle
//   lookup_valid, lpm_hit_out,
//   index_hit_out                    lookup result (hit/index held between results)
//   lpm_result0..31                  {oq, next_hop} of every entry
//   lpm_hit_count, lpm_miss_count,
//   stats_clear                      lookup statistics
// Build option: define LPM_STATS_EN to enable the hit/miss counters; otherwise
// they read as 0 and stats_clear is ignored.
module lpm_table_match #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int LPM_DEPTH          = lpm_pkg::LPM_DEPTH,
  parameter int LPM_ADDR_WIDTH     = lpm_pkg::LPM_ADDR_WIDTH
) (
  input  logic                            AXI_ACLK,
  input  logic                            AXI_RESET,
  input  logic                            tbl_wr_req,
  input  logic [LPM_ADDR_WIDTH-1:0]       tbl_wr_addr,
  input  logic [4*C_S_AXI_DATA_WIDTH-1:0] tbl_wr_data,
  output logic                            tbl_wr_ack,
  input  logic                            tbl_rd_req,
  input  logic [LPM_ADDR_WIDTH-1:0]       tbl_rd_addr,
  output logic [4*C_S_AXI_DATA_WIDTH-1:0] tbl_rd_data,
  output logic                            tbl_rd_ack,
  input  logic                            lookup_req,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   lookup_ip,
  output logic                            lookup_valid,
  output logic                            lpm_hit_out,
  output logic [LPM_ADDR_WIDTH-1:0]       index_hit_out,
  output logic [2*C_S_AXI_DATA_WIDTH-1:0] lpm_result0,
  output logic [2*C_S_AXI_DATA_WIDTH-1:0] lpm_result1,
  output logic [2*C_S_AXI_DATA_WIDTH-1:0] lpm_result2,
  output logic [2*C_S_AXI_DATA_WIDTH-1:0] lpm_result3,
  output logic [2*C_S_AXI_DATA_WIDTH-1:0] lpm_result4,
  output logic [2*C_S_AXI_DATA_WIDTH-1:0] lpm_result5,
  output logic [2*C_S_AXI_DATA_WIDTH-1:0] lpm_result6,
  output logic [2*C_S_AXI_DATA_WIDTH-1:0] lpm_result7,
  output logic [2*C_S_AXI_DATA_WIDTH-1:0] lpm_result8,
  output logic [2*C_S_AXI_DATA_WIDTH-1:0] lpm_result9,
  output logic [2*C_S_AXI_DATA_WIDTH-1:0] lpm_result10,
  output logic [2*C_S_AXI_DATA_WIDTH-1:0] lpm_result11,
  output logic [2*C_S_AXI_DATA_WIDTH-1:0] lpm_result12,
  output logic [2*C_S_AXI_DATA_WIDTH-1:0] lpm_result13,
  output logic [2*C_S_AXI_DATA_WIDTH-1:0] lpm_result14,
  output logic [2*C_S_AXI_DATA_WIDTH-1:0] lpm_result15,
  output logic [2*C_S_AXI_DATA_WIDTH-1:0] lpm_result16,
  output logic [2*C_S_AXI_DATA_WIDTH-1:0] lpm_result17,
  output logic [2*C_S_AXI_DATA_WIDTH-1:0] lpm_result18,
  output logic [2*C_S_AXI_DATA_WIDTH-1:0] lpm_result19,
  output logic [2*C_S_AXI_DATA_WIDTH-1:0] lpm_result20,
  output logic [2*C_S_AXI_DATA_WIDTH-1:0] lpm_result21,
  output logic [2*C_S_AXI_DATA_WIDTH-1:0] lpm_result22,
  output logic [2*C_S_AXI_DATA_WIDTH-1:0] lpm_result23,
  output logic [2*C_S_AXI_DATA_WIDTH-1:0] lpm_result24,
  output logic [2*C_S_AXI_DATA_WIDTH-1:0] lpm_result25,
  output logic [2*C_S_AXI_DATA_WIDTH-1:0] lpm_result26,
  output logic [2*C_S_AXI_DATA_WIDTH-1:0] lpm_result27,
  output logic [2*C_S_AXI_DATA_WIDTH-1:0] lpm_result28,
  output logic [2*C_S_AXI_DATA_WIDTH-1:0] lpm_result29,
  output logic [2*C_S_AXI_DATA_WIDTH-1:0] lpm_result30,
  output logic [2*C_S_AXI_DATA_WIDTH-1:0] lpm_result31,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   lpm_miss_count,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   lpm_hit_count,
  input  logic                            stats_clear
);

  import lpm_pkg::*;

  lpm_entry_t                 tbl [LPM_DEPTH];
  logic [LPM_DEPTH-1:0]       valid;
  logic [LPM_DEPTH-1:0]       match_c;
  logic [LPM_DEPTH-1:0]       match_q;
  logic                       s1_v;
  logic                       enc_any;
  logic [LPM_ADDR_WIDTH-1:0]  enc_index;

  // An all-zero write deletes the entry; any nonzero field makes it live,
  // which is how a 0.0.0.0/0 default route with a real oq/nh stays valid.
  always_ff @(posedge AXI_ACLK or posedge AXI_RESET) begin
    if (AXI_RESET) begin
      for (int i = 0; i < LPM_DEPTH; i++) tbl[i] <= '0;
      valid      <= '0;
      tbl_wr_ack <= 1'b0;
    end else begin
      tbl_wr_ack <= tbl_wr_req;
      if (tbl_wr_req) begin
        tbl[tbl_wr_addr]   <= tbl_wr_data;
        valid[tbl_wr_addr] <= |tbl_wr_data;
      end
    end
  end

  // Reads sample the register array before this edge's write lands, so a
  // same-cycle read/write of one address returns the old contents.
  always_ff @(posedge AXI_ACLK or posedge AXI_RESET) begin
    if (AXI_RESET) begin
      tbl_rd_ack  <= 1'b0;
      tbl_rd_data <= '0;
    end else begin
      tbl_rd_ack <= tbl_rd_req;
      if (tbl_rd_req) tbl_rd_data <= tbl[tbl_rd_addr];
    end
  end

  always_comb begin
    match_c = '0;
    for (int i = 0; i < LPM_DEPTH; i++) begin
      match_c[i] = valid[i] & entry_match(tbl[i], lookup_ip);
    end
  end

  // Stage 1 registers the match vector; stage 2 priority-encodes it.
  always_ff @(posedge AXI_ACLK or posedge AXI_RESET) begin
    if (AXI_RESET) begin
      match_q <= '0;
      s1_v    <= 1'b0;
    end else begin
      s1_v <= lookup_req;
      if (lookup_req) match_q <= match_c;
    end
  end

  lpm_prio_enc32 u_prio_enc (
    .vec   (match_q),
    .any   (enc_any),
    .index (enc_index)
  );

  // Hit and index only move when a result is produced; otherwise they hold.
  always_ff @(posedge AXI_ACLK or posedge AXI_RESET) begin
    if (AXI_RESET) begin
      lookup_valid  <= 1'b0;
      lpm_hit_out   <= 1'b0;
      index_hit_out <= '0;
    end else begin
      lookup_valid <= s1_v;
      if (s1_v) begin
        lpm_hit_out   <= enc_any;
        index_hit_out <= enc_index;
      end
    end
  end

`ifdef LPM_STATS_EN
  // Counters follow the lookup_valid pulse; a clear wins over a same-cycle count.
  always_ff @(posedge AXI_ACLK or posedge AXI_RESET) begin
    if (AXI_RESET) begin
      lpm_hit_count  <= '0;
      lpm_miss_count <= '0;
    end else if (stats_clear) begin
      lpm_hit_count  <= '0;
      lpm_miss_count <= '0;
    end else if (lookup_valid) begin
      if (lpm_hit_out) lpm_hit_count  <= lpm_hit_count + 1'b1;
      else             lpm_miss_count <= lpm_miss_count + 1'b1;
    end
  end
`else
  logic unused_stats_clear;
  assign unused_stats_clear = stats_clear;
  assign lpm_hit_count      = '0;
  assign lpm_miss_count     = '0;
`endif

  assign lpm_result0  = tbl[0][LPM_OQ_MSB:LPM_NH_LSB];
  assign lpm_result1  = tbl[1][LPM_OQ_MSB:LPM_NH_LSB];
  assign lpm_result2  = tbl[2][LPM_OQ_MSB:LPM_NH_LSB];
  assign lpm_result3  = tbl[3][LPM_OQ_MSB:LPM_NH_LSB];
  assign lpm_result4  = tbl[4][LPM_OQ_MSB:LPM_NH_LSB];
  assign lpm_result5  = tbl[5][LPM_OQ_MSB:LPM_NH_LSB];
  assign lpm_result6  = tbl[6][LPM_OQ_MSB:LPM_NH_LSB];
  assign lpm_result7  = tbl[7][LPM_OQ_MSB:LPM_NH_LSB];
  assign lpm_result8  = tbl[8][LPM_OQ_MSB:LPM_NH_LSB];
  assign lpm_result9  = tbl[9][LPM_OQ_MSB:LPM_NH_LSB];
  assign lpm_result10 = tbl[10][LPM_OQ_MSB:LPM_NH_LSB];
  assign lpm_result11 = tbl[11][LPM_OQ_MSB:LPM_NH_LSB];
  assign lpm_result12 = tbl[12][LPM_OQ_MSB:LPM_NH_LSB];
  assign lpm_result13 = tbl[13][LPM_OQ_MSB:LPM_NH_LSB];
  assign lpm_result14 = tbl[14][LPM_OQ_MSB:LPM_NH_LSB];
  assign lpm_result15 = tbl[15][LPM_OQ_MSB:LPM_NH_LSB];
  assign lpm_result16 = tbl[16][LPM_OQ_MSB:LPM_NH_LSB];
  assign lpm_result17 = tbl[17][LPM_OQ_MSB:LPM_NH_LSB];
  assign lpm_result18 = tbl[18][LPM_OQ_MSB:LPM_NH_LSB];
  assign lpm_result19 = tbl[19][LPM_OQ_MSB:LPM_NH_LSB];
  assign lpm_result20 = tbl[20][LPM_OQ_MSB:LPM_NH_LSB];
  assign lpm_result21 = tbl[21][LPM_OQ_MSB:LPM_NH_LSB];
  assign lpm_result22 = tbl[22][LPM_OQ_MSB:LPM_NH_LSB];
  assign lpm_result23 = tbl[23][LPM_OQ_MSB:LPM_NH_LSB];
  assign lpm_result24 = tbl[24][LPM_OQ_MSB:LPM_NH_LSB];
  assign lpm_result25 = tbl[25][LPM_OQ_MSB:LPM_NH_LSB];
  assign lpm_result26 = tbl[26][LPM_OQ_MSB:LPM_NH_LSB];
  assign lpm_result27 = tbl[27][LPM_OQ_MSB:LPM_NH_LSB];
  assign lpm_result28 = tbl[28][LPM_OQ_MSB:LPM_NH_LSB];
  assign lpm_result29 = tbl[29][LPM_OQ_MSB:LPM_NH_LSB];
  assign lpm_result30 = tbl[30][LPM_OQ_MSB:LPM_NH_LSB];
  assign lpm_result31 = tbl[31][LPM_OQ_MSB:LPM_NH_LSB];

endmodule

// File: tb/tb_lpm_table_match.sv
// tb_lpm_table_match: self-checking bench for lpm_table_match.
// Lookups push their expected {hit, index, arrival cycle} into a scoreboard
// queue when driven; a negedge monitor pops and compares when lookup_valid
// is due. Define LPM_STATS_EN for both bench and RTL to cover the counters.
module tb_lpm_table_match;

  logic         clk;
  logic         rst;
  logic         tbl_wr_req;
  logic [4:0]   tbl_wr_addr;
  logic [127:0] tbl_wr_data;
  logic         tbl_wr_ack;
  logic         tbl_rd_req;
  logic [4:0]   tbl_rd_addr;
  logic [127:0] tbl_rd_data;
  logic         tbl_rd_ack;
  logic         lookup_req;
  logic [31:0]  lookup_ip;
  logic         lookup_valid;
  logic         lpm_hit_out;
  logic [4:0]   index_hit_out;
  logic [63:0]  res [32];
  logic [31:0]  lpm_miss_count;
  logic [31:0]  lpm_hit_count;
  logic         stats_clear;

  typedef struct {
    int         due;
    logic       hit;
    logic [4:0] idx;
  } exp_t;

  exp_t         sb_q [$];
  logic [127:0] m_tbl [32];
  logic [31:0]  m_valid;
  logic [127:0] rd_exp;
  int           cyc;
  int           checks;
  int           failures;

  lpm_table_match dut (
    .AXI_ACLK(clk), .AXI_RESET(rst),
    .tbl_wr_req(tbl_wr_req), .tbl_wr_addr(tbl_wr_addr), .tbl_wr_data(tbl_wr_data),
    .tbl_wr_ack(tbl_wr_ack),
    .tbl_rd_req(tbl_rd_req), .tbl_rd_addr(tbl_rd_addr), .tbl_rd_data(tbl_rd_data),
    .tbl_rd_ack(tbl_rd_ack),
    .lookup_req(lookup_req), .lookup_ip(lookup_ip), .lookup_valid(lookup_valid),
    .lpm_hit_out(lpm_hit_out), .index_hit_out(index_hit_out),
    .lpm_result0(res[0]),   .lpm_result1(res[1]),   .lpm_result2(res[2]),   .lpm_result3(res[3]),
    .lpm_result4(res[4]),   .lpm_result5(res[5]),   .lpm_result6(res[6]),   .lpm_result7(res[7]),
    .lpm_result8(res[8]),   .lpm_result9(res[9]),   .lpm_result10(res[10]), .lpm_result11(res[11]),
    .lpm_result12(res[12]), .lpm_result13(res[13]), .lpm_result14(res[14]), .lpm_result15(res[15]),
    .lpm_result16(res[16]), .lpm_result17(res[17]), .lpm_result18(res[18]), .lpm_result19(res[19]),
    .lpm_result20(res[20]), .lpm_result21(res[21]), .lpm_result22(res[22]), .lpm_result23(res[23]),
    .lpm_result24(res[24]), .lpm_result25(res[25]), .lpm_result26(res[26]), .lpm_result27(res[27]),
    .lpm_result28(res[28]), .lpm_result29(res[29]), .lpm_result30(res[30]), .lpm_result31(res[31]),
    .lpm_miss_count(lpm_miss_count), .lpm_hit_count(lpm_hit_count),
    .stats_clear(stats_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks = checks + 1;
    if (obs !== exp) begin
      failures = failures + 1;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] mk(input logic [31:0] ip, input logic [31:0] mask,
                                      input logic [31:0] oq, input logic [31:0] nh);
    return {ip, mask, oq, nh};
  endfunction

  // Reference lookup: lowest valid index whose prefix covers ip.
  function automatic logic [5:0] modelLookup(input logic [31:0] ip);
    logic [127:0] e;
    for (int i = 0; i < 32; i++) begin
      e = m_tbl[i];
      if (m_valid[i] && ((ip & e[95:64]) == (e[127:96] & e[95:64])))
        return {1'b1, 5'(i)};
    end
    return 6'd0;
  endfunction

  function automatic void modelClear();
    for (int i = 0; i < 32; i++) m_tbl[i] = '0;
    m_valid = '0;
  endfunction

  // Within one cycle call startRead/startLookup before startWrite so their
  // expectations see the pre-write table.
  task automatic startWrite(input logic [4:0] addr, input logic [127:0] data);
    tbl_wr_req  = 1'b1;
    tbl_wr_addr = addr;
    tbl_wr_data = data;
    m_tbl[addr]   = data;
    m_valid[addr] = |data;
  endtask

  task automatic startRead(input logic [4:0] addr);
    tbl_rd_req  = 1'b1;
    tbl_rd_addr = addr;
    rd_exp      = m_tbl[addr];
  endtask

  task automatic startLookupK(input logic [31:0] ip, input logic hit, input logic [4:0] idx);
    exp_t e;
    lookup_req = 1'b1;
    lookup_ip  = ip;
    e.due = cyc + 2;
    e.hit = hit;
    e.idx = idx;
    sb_q.push_back(e);
  endtask

  task automatic startLookup(input logic [31:0] ip);
    logic [5:0] r;
    r = modelLookup(ip);
    startLookupK(ip, r[5], r[4:0]);
  endtask

  // Advance one cycle (to the next negedge) and drop all request pulses.
  task automatic applyStimulus();
    @(negedge clk);
    tbl_wr_req  = 1'b0;
    tbl_rd_req  = 1'b0;
    lookup_req  = 1'b0;
    stats_clear = 1'b0;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  // Scoreboard monitor: lookup_valid must pulse exactly when an entry is due.
  always @(negedge clk) begin
    logic due_now;
    exp_t e;
    if (!rst) begin
      due_now = (sb_q.size() > 0) && (sb_q[0].due == cyc);
      checkOutput("lookup_valid", {127'd0, lookup_valid}, {127'd0, due_now});
      if (due_now) begin
        e = sb_q.pop_front();
        checkOutput("lpm_hit_out", {127'd0, lpm_hit_out}, {127'd0, e.hit});
        checkOutput("index_hit_out", {123'd0, index_hit_out}, {123'd0, e.idx});
      end
    end
  end

  initial begin
    logic [31:0] pool [6];
    checks = 0; failures = 0; cyc = 0;
    rst = 1'b1;
    tbl_wr_req = 0; tbl_wr_addr = 0; tbl_wr_data = 0;
    tbl_rd_req = 0; tbl_rd_addr = 0;
    lookup_req = 0; lookup_ip = 0; stats_clear = 0;
    modelClear();
    drain(2);

    // Reset state
    checkOutput("rst_wr_ack", {127'd0, tbl_wr_ack}, 0);
    checkOutput("rst_rd_ack", {127'd0, tbl_rd_ack}, 0);
    checkOutput("rst_rd_data", tbl_rd_data, 0);
    checkOutput("rst_lookup_valid", {127'd0, lookup_valid}, 0);
    checkOutput("rst_hit", {127'd0, lpm_hit_out}, 0);
    checkOutput("rst_idx", {123'd0, index_hit_out}, 0);
    checkOutput("rst_result0", {64'd0, res[0]}, 0);
    checkOutput("rst_hit_count", {96'd0, lpm_hit_count}, 0);
    rst = 1'b0;
    applyStimulus();

    // Single /24 entry, write ack timing and result export
    startWrite(0, mk(32'h0A000100, 32'hFFFFFF00, 32'd2, 32'h0A000101));
    applyStimulus();
    checkOutput("t1_wr_ack", {127'd0, tbl_wr_ack}, 1);
    checkOutput("t1_result0", {64'd0, res[0]}, {64'd0, 64'h00000002_0A000101});
    applyStimulus();
    checkOutput("t1_wr_ack_low", {127'd0, tbl_wr_ack}, 0);
    startLookupK(32'h0A000107, 1'b1, 5'd0);
    drain(4);
    checkOutput("t1_hit_held", {127'd0, lpm_hit_out}, 1);

    // /8 entry at index 3, back-to-back lookups
    startWrite(3, mk(32'h0A000000, 32'hFF000000, 32'd1, 32'd0));
    applyStimulus();
    startLookupK(32'h0A000107, 1'b1, 5'd0);
    applyStimulus();
    startLookupK(32'h0A050505, 1'b1, 5'd3);
    drain(4);
    checkOutput("t2_idx_held", {123'd0, index_hit_out}, 3);

    // Miss, then default route at 31
    startLookupK(32'hC0A80101, 1'b0, 5'd0);
    drain(4);
    startWrite(31, mk(32'd0, 32'd0, 32'd4, 32'd0));
    applyStimulus();
    startLookupK(32'hC0A80101, 1'b1, 5'd31);
    drain(4);

    // Write and lookup in the same cycle: lookup sees the old table
    startLookupK(32'hC0A80101, 1'b1, 5'd31);
    startWrite(1, mk(32'hC0A80100, 32'hFFFFFF00, 32'd7, 32'hC0A801FE));
    applyStimulus();
    startLookupK(32'hC0A80101, 1'b1, 5'd1);
    drain(4);
    startWrite(1, 128'd0);
    applyStimulus();
    startLookupK(32'hC0A80101, 1'b1, 5'd31);
    drain(4);

    // Same-cycle read/write of e5 returns old data
    startWrite(5, mk(32'h11223344, 32'hFFFF0000, 32'd9, 32'h55667788));
    applyStimulus();
    startRead(5);
    startWrite(5, 128'h1);
    applyStimulus();
    checkOutput("t4_rd_ack", {127'd0, tbl_rd_ack}, 1);
    checkOutput("t4_wr_ack", {127'd0, tbl_wr_ack}, 1);
    checkOutput("t4_rd_old", tbl_rd_data, mk(32'h11223344, 32'hFFFF0000, 32'd9, 32'h55667788));
    applyStimulus();
    checkOutput("t4_rd_ack_low", {127'd0, tbl_rd_ack}, 0);
    checkOutput("t4_rd_held", tbl_rd_data, rd_exp);
    startRead(5);
    applyStimulus();
    checkOutput("t4_rd_new", tbl_rd_data, 128'h1);
    startWrite(5, 128'd0);
    applyStimulus();

    // Consecutive reads each get their own ack
    startRead(0);
    applyStimulus();
    checkOutput("rd0_data", tbl_rd_data, rd_exp);
    startRead(3);
    applyStimulus();
    checkOutput("rd3_ack", {127'd0, tbl_rd_ack}, 1);
    checkOutput("rd3_data", tbl_rd_data, rd_exp);

    // Random back-to-back lookups against the reference model
    startWrite(7, mk(32'h0B000000, 32'hFFFF0000, 32'd3, 32'h0B000001));
    applyStimulus();
    pool[0] = 32'h0A000107; pool[1] = 32'h0A050505; pool[2] = 32'hC0A80101;
    pool[3] = 32'h0B000042; pool[4] = 32'h0A0001FF; pool[5] = 32'h0B010001;
    for (int i = 0; i < 24; i++) begin
      if (i % 4 == 3) startLookup($urandom);
      else            startLookup(pool[$urandom_range(0, 5)]);
      applyStimulus();
    end
    drain(4);
    for (int i = 0; i < 32; i++)
      checkOutput($sformatf("result%0d", i), {64'd0, res[i]}, {64'd0, m_tbl[i][63:0]});

    // Reset with a lookup in flight: it must be dropped
    startLookup(32'h0A000107);
    applyStimulus();
    rst = 1'b1;
    void'(sb_q.pop_back());
    modelClear();
    #1;
    checkOutput("t5_lookup_valid", {127'd0, lookup_valid}, 0);
    checkOutput("t5_hit", {127'd0, lpm_hit_out}, 0);
    checkOutput("t5_idx", {123'd0, index_hit_out}, 0);
    checkOutput("t5_rd_data", tbl_rd_data, 0);
    checkOutput("t5_result0", {64'd0, res[0]}, 0);
    checkOutput("t5_result31", {64'd0, res[31]}, 0);
    applyStimulus();
    rst = 1'b0;
    drain(3);
    startLookupK(32'h0A000107, 1'b0, 5'd0);
    drain(4);

    // Statistics
    startWrite(0, mk(32'h0A000100, 32'hFFFFFF00, 32'd2, 32'h0A000101));
    applyStimulus();
    for (int i = 0; i < 3; i++) begin startLookupK(32'h0A000107, 1'b1, 5'd0); applyStimulus(); end
    for (int i = 0; i < 2; i++) begin startLookupK(32'hC0A80101, 1'b0, 5'd0); applyStimulus(); end
    drain(4);
`ifdef LPM_STATS_EN
    checkOutput("t6_hit_count", {96'd0, lpm_hit_count}, 3);
    checkOutput("t6_miss_count", {96'd0, lpm_miss_count}, 2);
    startLookupK(32'h0A000107, 1'b1, 5'd0);
    drain(2);
    stats_clear = 1'b1;
    applyStimulus();
    checkOutput("t6_clr_hit", {96'd0, lpm_hit_count}, 0);
    checkOutput("t6_clr_miss", {96'd0, lpm_miss_count}, 0);
`else
    startLookupK(32'h0A000107, 1'b1, 5'd0);
    drain(2);
    stats_clear = 1'b1;
    applyStimulus();
    checkOutput("t6_off_hit", {96'd0, lpm_hit_count}, 0);
    checkOutput("t6_off_miss", {96'd0, lpm_miss_count}, 0);
`endif
    drain(4);
    checkOutput("sb_empty", 128'(sb_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
